// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Parallel-to-serial frame transmitter. Each accepted word is sent on a
//   single idle-high line as: "001" preamble, payload MSB-first, optional
//   even-parity bit, then GAP_BITS forced idle-high bit times. The preamble
//   lets a downstream "001" detector find the frame start.
//
// Parameters
//   DATA_W    payload width (2..32)
//   PARITY_EN 1 = append even-parity bit, 0 = none
//   GAP_BITS  idle-high bit times after each frame (0..15)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   tx_valid   tx_data holds a word to send
//   tx_data    payload word
//   tx_ready   word accepted this cycle if tx_valid is also high (IDLE only)
//   s_out      registered serial line, idle = 1
//   busy       frame in progress
//   frame_done one-cycle pulse while s_out carries the last frame bit
module serial_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP_BITS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              s_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_DATA    = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_DATA_M1 = CNT_W'(DATA_W - 2);
  localparam logic [CNT_W-1:0] LAST_GAP     = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE0 = 3'd1,
    PRE1 = 3'd2,
    PRE2 = 3'd3,
    DATA = 3'd4,
    PAR  = 3'd5,
    GAP  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               par_q, par_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s_out_q, s_out_d;
  logic               fd_q, fd_d;

  // State register; s_out is registered so the state names the bit
  // currently on the line and the comb logic computes the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      s_out_q <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      s_out_q <= s_out_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    s_out_d = 1'b1;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // tx_ready is 1 whenever IDLE is held outside reset.
        if (tx_valid) begin
          state_d = PRE0;
          shreg_d = tx_data;
          par_d   = ^tx_data;
          cnt_d   = '0;
          s_out_d = 1'b0;
        end
      end
      PRE0: begin
        state_d = PRE1;
        s_out_d = 1'b0;
      end
      PRE1: begin
        state_d = PRE2;
        s_out_d = 1'b1;
      end
      PRE2: begin
        state_d = DATA;
        s_out_d = shreg_q[DATA_W-1];
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_DATA) begin
          cnt_d = '0;
          if (PARITY_EN != 0) begin
            state_d = PAR;
            s_out_d = par_q;
            fd_d    = 1'b1;
          end else if (GAP_BITS != 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_out_d = shreg_q[DATA_W-1];
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
          // Without parity the final payload bit is the last frame bit.
          if ((PARITY_EN == 0) && (cnt_q == LAST_DATA_M1)) fd_d = 1'b1;
        end
      end
      PAR: begin
        cnt_d   = '0;
        state_d = (GAP_BITS != 0) ? GAP : IDLE;
      end
      GAP: begin
        if (cnt_q == LAST_GAP) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Unused encoding: fall back to a clean idle line.
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign tx_ready   = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE) && !rst;
  assign s_out      = s_out_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_valid2;
  logic [7:0] tx_data, tx_data2;
  logic       tx_ready, s_out, busy, frame_done;
  logic       tx_ready2, s_out2, busy2, frame_done2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Default configuration: L = 4 + 8 + 1 + 2 = 15
  serial_frame_tx #(.DATA_W(8), .PARITY_EN(1), .GAP_BITS(2)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .s_out(s_out), .busy(busy), .frame_done(frame_done)
  );

  // No parity, no gap: L = 12
  serial_frame_tx #(.DATA_W(8), .PARITY_EN(0), .GAP_BITS(0)) dut2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_data(tx_data2),
    .tx_ready(tx_ready2), .s_out(s_out2), .busy(busy2), .frame_done(frame_done2)
  );

  // Expected line value for frame bit i (i=0 is the cycle after handshake).
  function automatic logic exp_bit(input logic [7:0] w, input bit par_en, input int i);
    int j;
    if (i < 3) return (i == 2);
    j = i - 3;
    if (j < 8) return w[7 - j];
    j = j - 8;
    if (par_en && j == 0) return logic'($countones(w) % 2);
    return 1'b1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_valid2 = 1'b0; tx_data = '0; tx_data2 = '0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (s_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold c=%0d: s_out=%b busy=%b fd=%b rdy=%b, required 1 0 0 0",
                 c, s_out, busy, frame_done, tx_ready);
      end
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || s_out !== 1'b1 || busy !== 1'b0 || tx_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: rdy=%b s_out=%b busy=%b rdy2=%b, required 1 1 0 1",
               tx_ready, s_out, busy, tx_ready2);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] w = 8'hA5;
    cyc();
    tx_valid = 1'b1; tx_data = w;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready: tx_ready=%b required 1", tx_ready);
    end
    cyc();
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 1; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (s_out !== exp_bit(w, 1'b1, i - 1) || frame_done !== (i == 12) ||
          busy !== 1'b1 || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_T+%0d: s_out=%b fd=%b busy=%b rdy=%b, required %b %b 1 0",
                 i, s_out, frame_done, busy, tx_ready, exp_bit(w, 1'b1, i - 1), (i == 12));
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || s_out !== 1'b1) begin
      errors++;
      $display("FAIL single_T+15: rdy=%b busy=%b s_out=%b, required 1 0 1", tx_ready, busy, s_out);
    end
  endtask

  // 0x01 on both instances at once: parity 1 on dut, short frame on dut2.
  task automatic test_odd_parity();
    logic [7:0] w = 8'h01;
    tx_valid = 1'b1; tx_data = w; tx_valid2 = 1'b1; tx_data2 = w;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || tx_ready2 !== 1'b1) begin
      errors++; $display("FAIL odd_ready: rdy=%b rdy2=%b required 1 1", tx_ready, tx_ready2);
    end
    cyc();
    tx_valid = 1'b0; tx_valid2 = 1'b0; tx_data = 8'hFF; tx_data2 = 8'hFF;
    for (int i = 1; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (s_out !== exp_bit(w, 1'b1, i - 1) || frame_done !== (i == 12)) begin
        errors++;
        $display("FAIL odd_par_T+%0d: s_out=%b fd=%b, required %b %b",
                 i, s_out, frame_done, exp_bit(w, 1'b1, i - 1), (i == 12));
      end
      if (i < 12) begin
        checks++;
        if (s_out2 !== exp_bit(w, 1'b0, i - 1) || frame_done2 !== (i == 11) || busy2 !== 1'b1) begin
          errors++;
          $display("FAIL nopar_T+%0d: s_out=%b fd=%b busy=%b, required %b %b 1",
                   i, s_out2, frame_done2, busy2, exp_bit(w, 1'b0, i - 1), (i == 11));
        end
      end else if (i == 12) begin
        checks++;
        if (tx_ready2 !== 1'b1 || busy2 !== 1'b0 || s_out2 !== 1'b1 || frame_done2 !== 1'b0) begin
          errors++;
          $display("FAIL nopar_T+12: rdy=%b busy=%b s_out=%b fd=%b, required 1 0 1 0",
                   tx_ready2, busy2, s_out2, frame_done2);
        end
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL odd_T+15: tx_ready=%b required 1", tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0 = 8'h3C;
    logic [7:0] w1 = 8'hFF;
    tx_valid = 1'b1; tx_data = w0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready0: tx_ready=%b required 1", tx_ready);
    end
    cyc();
    tx_data = w1;  // changed mid-frame, must not affect frame 0
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (i == 15) begin
        if (tx_ready !== 1'b1 || s_out !== 1'b1) begin
          errors++;
          $display("FAIL b2b_handshake2: rdy=%b s_out=%b, required 1 1", tx_ready, s_out);
        end
      end else begin
        if (s_out !== exp_bit((i < 15) ? w0 : w1, 1'b1, (i < 15) ? i - 1 : i - 16) ||
            tx_ready !== 1'b0 || frame_done !== (i == 12 || i == 27)) begin
          errors++;
          $display("FAIL b2b_T+%0d: s_out=%b rdy=%b fd=%b, required %b 0 %b", i, s_out, tx_ready,
                   frame_done, exp_bit((i < 15) ? w0 : w1, 1'b1, (i < 15) ? i - 1 : i - 16),
                   (i == 12 || i == 27));
        end
      end
      cyc();
      if (i == 15) tx_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end: rdy=%b busy=%b, required 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_ignored_request();
    logic [7:0] w = 8'h96;
    tx_valid = 1'b1; tx_data = w;
    cyc();
    tx_valid = 1'b0;
    for (int i = 1; i < 20; i++) begin
      if (i == 5) begin tx_valid = 1'b1; tx_data = 8'h55; end
      else tx_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (i < 15) begin
        if (s_out !== exp_bit(w, 1'b1, i - 1) || frame_done !== (i == 12) || busy !== 1'b1) begin
          errors++;
          $display("FAIL ignore_T+%0d: s_out=%b fd=%b busy=%b, required %b %b 1",
                   i, s_out, frame_done, busy, exp_bit(w, 1'b1, i - 1), (i == 12));
        end
      end else begin
        if (s_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL ignore_idle_T+%0d: s_out=%b busy=%b fd=%b, required 1 0 0",
                   i, s_out, busy, frame_done);
        end
      end
      cyc();
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] wa = 8'hB6;
    logic [7:0] wb = 8'h0F;
    tx_valid = 1'b1; tx_data = wa;
    cyc();
    tx_valid = 1'b0;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (s_out !== exp_bit(wa, 1'b1, i - 1)) begin
        errors++;
        $display("FAIL abort_pre_T+%0d: s_out=%b required %b", i, s_out, exp_bit(wa, 1'b1, i - 1));
      end
      cyc();
    end
    rst = 1'b1;  // cycle T+7 carries the 4th payload bit
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (s_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_idle c=%0d: s_out=%b busy=%b fd=%b rdy=%b, required 1 0 0 1",
                 c, s_out, busy, frame_done, tx_ready);
      end
      cyc();
    end
    tx_valid = 1'b1; tx_data = wb;
    cyc();
    tx_valid = 1'b0; tx_data = 8'hAA;
    for (int i = 1; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (s_out !== exp_bit(wb, 1'b1, i - 1) || frame_done !== (i == 12)) begin
        errors++;
        $display("FAIL after_abort_T+%0d: s_out=%b fd=%b, required %b %b",
                 i, s_out, frame_done, exp_bit(wb, 1'b1, i - 1), (i == 12));
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL after_abort_end: tx_ready=%b required 1", tx_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    cyc();
    test_odd_parity();
    cyc();
    test_back_to_back();
    cyc();
    test_ignored_request();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
